// File: rtl/seg7_msg_sequencer.sv
// seg7_msg_sequencer: buffers symbol codes and plays them one at a time on a 7-segment decoder
module seg7_msg_sequencer #(
  parameter int DEPTH = 8,
  parameter int DWELL = 2,
  parameter int GAP   = 1,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int IW = $clog2(DEPTH),
  localparam int TW = $clog2(DWELL + GAP + 1)
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_sym,
  input  logic          start,
  input  logic          loop,
  input  logic          clear,
  input  logic          abort,
  output logic [5:0]    sym_out,
  output logic          blank,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_DONE} state_t;
  state_t        r_state, w_state_n, w_adv_state;
  logic [IW-1:0] r_idx, w_idx_n, w_adv_idx;
  logic [TW-1:0] r_tmr, w_tmr_n;
  logic [CW-1:0] r_count, w_cnt_nxt;
  logic [5:0]    r_buf [DEPTH];
  logic [5:0]    r_sym, w_sym_n;
  logic          r_blank, w_accept, w_more;
  assign in_ready = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
  assign busy     = (r_state == S_SHOW) || (r_state == S_GAP);
  assign done     = r_state == S_DONE;
  assign count    = r_count;
  assign sym_out  = r_sym;
  assign blank    = r_blank;
  always_comb begin
    w_accept    = in_valid && in_ready && !clear;
    w_cnt_nxt   = r_count + CW'(w_accept);
    w_more      = ({1'b0, r_idx} + CW'(1)) < r_count;
    w_adv_state = (w_more || loop) ? S_SHOW : S_DONE;
    w_adv_idx   = w_more ? r_idx + IW'(1) : '0;
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_tmr_n     = r_tmr + TW'(1);
    case (r_state)
      S_IDLE: begin
        w_tmr_n = '0;
        if (!clear && start && w_cnt_nxt != '0) begin
          w_state_n = S_SHOW;
          w_idx_n   = '0;
        end
      end
      S_SHOW: begin
        if (abort) begin
          w_state_n = S_IDLE;
          w_tmr_n   = '0;
        end else if (r_tmr == TW'(DWELL - 1)) begin
          w_tmr_n   = '0;
          w_state_n = (GAP > 0) ? S_GAP : w_adv_state;
          w_idx_n   = (GAP > 0) ? r_idx : w_adv_idx;
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_n = S_IDLE;
          w_tmr_n   = '0;
        end else if (r_tmr == TW'(GAP - 1)) begin
          w_tmr_n   = '0;
          w_state_n = w_adv_state;
          w_idx_n   = w_adv_idx;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tmr_n   = '0;
      end
    endcase
    // a symbol accepted in the same cycle as start is not yet in the buffer
    w_sym_n = (r_state == S_IDLE && r_count == '0) ? in_sym : r_buf[w_idx_n];
  end
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tmr   <= '0;
      r_count <= '0;
      r_sym   <= '0;
      r_blank <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_tmr   <= w_tmr_n;
      if (r_state == S_IDLE) r_count <= clear ? '0 : w_cnt_nxt;
      if (w_state_n == S_SHOW) r_sym <= w_sym_n;
      r_blank <= w_state_n != S_SHOW;
    end
  end
  always_ff @(posedge clk_2) begin
    if (w_accept) r_buf[r_count[IW-1:0]] <= in_sym;
  end
endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// tb_seg7_msg_sequencer: scoreboard bench; a frame-list model predicts every cycle's outputs
module tb_seg7_msg_sequencer;
  localparam int DEPTH = 8, DWELL = 2, GAP = 1;
  logic clk_2 = 0, reset = 0, in_valid = 0, in_ready, start = 0, loop = 0, clear = 0, abort = 0;
  logic [5:0] in_sym = 0, sym_out;
  logic blank, busy, done;
  logic [3:0] count;
  typedef struct packed {
    logic [5:0] sym;
    logic blank, busy, done;
    logic [3:0] count;
    logic ready;
  } frame_t;
  frame_t sb[$], plan[$];
  int mq[$];
  logic [5:0] m_sym = 0;
  bit playing = 0, in_done = 0;
  int n_chk = 0, n_fail = 0, cyc_no = 0;
  seg7_msg_sequencer #(.DEPTH(DEPTH), .DWELL(DWELL), .GAP(GAP)) dut (
    .clk_2(clk_2), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .start(start), .loop(loop), .clear(clear), .abort(abort), .sym_out(sym_out),
    .blank(blank), .busy(busy), .done(done), .count(count)
  );
  always #5 clk_2 = ~clk_2;
  function automatic frame_t idle_f();
    return '{m_sym, 1'b1, 1'b0, 1'b0, 4'(mq.size()), mq.size() < DEPTH};
  endfunction
  // one pass = every buffered code shown DWELL cycles then blanked GAP cycles
  function automatic void gen_pass();
    foreach (mq[i]) begin
      for (int d = 0; d < DWELL; d++) plan.push_back('{6'(mq[i]), 1'b0, 1'b1, 1'b0, 4'(mq.size()), 1'b0});
      for (int g = 0; g < GAP; g++) plan.push_back('{6'(mq[i]), 1'b1, 1'b1, 1'b0, 4'(mq.size()), 1'b0});
    end
  endfunction
  function automatic void take();
    frame_t f;
    f = plan.pop_front();
    m_sym = f.sym;
    sb.push_back(f);
  endfunction
  task automatic cyc(input logic v, input logic [5:0] s, input logic st, lp, clr, ab, rs);
    in_valid = v; in_sym = s; start = st; loop = lp; clear = clr; abort = ab; reset = rs;
    if (rs) begin
      mq.delete(); plan.delete(); playing = 0; in_done = 0; m_sym = 0;
      sb.push_back('{6'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1});
    end else if (in_done) begin
      in_done = 0;
      sb.push_back(idle_f());
    end else if (playing) begin
      if (ab) begin
        plan.delete(); playing = 0;
        sb.push_back(idle_f());
      end else begin
        if (plan.size() == 0 && lp) gen_pass();
        if (plan.size() == 0) begin
          playing = 0; in_done = 1;
          sb.push_back('{m_sym, 1'b1, 1'b0, 1'b1, 4'(mq.size()), 1'b0});
        end else take();
      end
    end else begin
      if (clr) mq.delete();
      else begin
        if (v && mq.size() < DEPTH) mq.push_back(int'(s));
        if (st && mq.size() > 0) begin
          gen_pass(); playing = 1; take();
        end
      end
      if (!playing) sb.push_back(idle_f());
    end
    @(posedge clk_2);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic load(input logic [5:0] s);
    cyc(1, s, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk_2) begin
    frame_t e, a;
    cyc_no++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{sym_out, blank, busy, done, count, in_ready};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL frame cyc=%0d got sym=%0d blank=%b busy=%b done=%b count=%0d ready=%b exp sym=%0d blank=%b busy=%b done=%b count=%0d ready=%b",
                 cyc_no, a.sym, a.blank, a.busy, a.done, a.count, a.ready, e.sym, e.blank, e.busy, e.done, e.count, e.ready);
      end
    end
  end
  initial begin
    #1;
    cyc(0, 0, 0, 0, 0, 0, 1);
    load(3); load(10); load(33);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(12);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) load(6'(40 + i));
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(27);
    cyc(0, 0, 0, 0, 1, 0, 0);
    load(1); load(2);
    cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    idle(8);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    cyc(1, 7, 1, 0, 0, 0, 0);
    idle(5);
    cyc(1, 9, 1, 0, 1, 0, 0);
    idle(2);
    load(5); load(63);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) cyc(0, 0, 0, 0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 1, 0, 0);
      for (int k = $urandom_range(0, 10); k > 0; k--) load(6'($urandom_range(0, 63)));
      cyc(1'($urandom), 6'($urandom), 1, 1'($urandom), 0, 0, 0);
      for (int c = 0; c < 50; c++)
        cyc(1'($urandom), 6'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 150) == 0));
    end
    idle(2);
    @(negedge clk_2);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
